// File: rtl/prog_mem_sync.sv
// Writable synchronous program memory for the CPU fetch stage.
// Cleared to NOP after reset, reloaded at run time through a valid/ready loader port.
module prog_mem_sync #(
  parameter int unsigned DATA_W = 35,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_oob,
  input  logic              load_start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic [ADDR_W:0]   load_count,
  output logic              load_err,
  output logic              busy
);

  localparam int unsigned      MemAw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DepthL   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]  CountMax = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [MemAw-1:0] LastPtr  = MemAw'(DEPTH - 1);

  if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : gen_depth_check
    $error("prog_mem_sync: DEPTH must be in 1..2**ADDR_W");
  end

  typedef enum logic [1:0] {StClear, StRun, StLoad} state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q;
  logic [MemAw-1:0]  clr_ptr_q;
  logic              fetch_valid_q;
  logic [DATA_W-1:0] fetch_data_q;
  logic              fetch_oob_q;
  logic [ADDR_W:0]   load_count_q;
  logic              load_err_q;

  logic              fetch_in_range;
  logic              load_in_range;
  logic              fetch_take;
  logic              load_take;
  logic              mem_we;
  logic [MemAw-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign fetch_in_range = {1'b0, fetch_addr} < DepthL;
  assign load_in_range  = {1'b0, load_addr} < DepthL;
  assign fetch_take     = (state_q == StRun) && fetch_req;
  assign load_take      = (state_q == StLoad) && load_valid;

  // Single write port shared by the clear sweep and the loader.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_ptr_q;
    mem_wdata = '0;
    unique case (state_q)
      StClear: mem_we = 1'b1;
      StLoad: begin
        if (load_take && load_in_range) begin
          mem_we    = 1'b1;
          mem_waddr = load_addr[MemAw-1:0];
          mem_wdata = load_data;
        end
      end
      default: ;
    endcase
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StClear;
      clr_ptr_q     <= '0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
      fetch_oob_q   <= 1'b0;
      load_count_q  <= '0;
      load_err_q    <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_take;
      fetch_oob_q   <= fetch_take && !fetch_in_range;
      // Synchronous read straight into the output register; holds when idle.
      if (fetch_take) begin
        fetch_data_q <= fetch_in_range ? mem[fetch_addr[MemAw-1:0]] : '0;
      end

      unique case (state_q)
        StClear: begin
          clr_ptr_q <= clr_ptr_q + MemAw'(1);
          if (clr_ptr_q == LastPtr) begin
            clr_ptr_q <= '0;
            state_q   <= StRun;
          end
        end
        StRun: begin
          if (load_start) begin
            state_q      <= StLoad;
            load_count_q <= '0;
            load_err_q   <= 1'b0;
          end
        end
        StLoad: begin
          if (load_take) begin
            if (load_count_q != CountMax) begin
              load_count_q <= load_count_q + (ADDR_W + 1)'(1);
            end
            if (!load_in_range) begin
              load_err_q <= 1'b1;
            end
            if (load_last) begin
              state_q <= StRun;
            end
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

  assign fetch_ready = (state_q == StRun);
  assign load_ready  = (state_q == StLoad);
  assign busy        = (state_q != StRun);
  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_data_q;
  assign fetch_oob   = fetch_oob_q;
  assign load_count  = load_count_q;
  assign load_err    = load_err_q;

endmodule

// File: tb/tb_prog_mem_sync.sv
// Directed bench for prog_mem_sync: one full-depth and one partial-depth instance
// share the same stimulus; each check uses hand-computed expected values.
module tb_prog_mem_sync;

  localparam int unsigned DW = 35;
  localparam int unsigned AW = 8;

  logic          clk;
  logic          reset;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          load_start;
  logic          load_valid;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          load_last;

  logic          a_fetch_ready, a_fetch_valid, a_fetch_oob, a_load_ready, a_load_err, a_busy;
  logic [DW-1:0] a_fetch_data;
  logic [AW:0]   a_load_count;
  logic          b_fetch_ready, b_fetch_valid, b_fetch_oob, b_load_ready, b_load_err, b_busy;
  logic [DW-1:0] b_fetch_data;
  logic [AW:0]   b_load_count;

  int n_cmp = 0;
  int n_err = 0;

  prog_mem_sync #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256)) u_dut_a (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(a_fetch_ready),
    .fetch_valid(a_fetch_valid), .fetch_data(a_fetch_data), .fetch_oob(a_fetch_oob),
    .load_start(load_start), .load_valid(load_valid), .load_ready(a_load_ready),
    .load_addr(load_addr), .load_data(load_data), .load_last(load_last),
    .load_count(a_load_count), .load_err(a_load_err), .busy(a_busy)
  );

  prog_mem_sync #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(100)) u_dut_b (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(b_fetch_ready),
    .fetch_valid(b_fetch_valid), .fetch_data(b_fetch_data), .fetch_oob(b_fetch_oob),
    .load_start(load_start), .load_valid(load_valid), .load_ready(b_load_ready),
    .load_addr(load_addr), .load_data(load_data), .load_last(load_last),
    .load_count(b_load_count), .load_err(b_load_err), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch1(input logic [AW-1:0] addr);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    tick();
    fetch_req  = 1'b0;
  endtask

  task automatic load_word(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic last);
    load_valid = 1'b1;
    load_addr  = addr;
    load_data  = data;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic wait_clear(input string tag);
    int ca, cb;
    ca = 0;
    cb = 0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (!b_busy && cb == 0) cb = i;
      if (!a_busy && ca == 0) ca = i;
      if (ca != 0 && cb != 0) break;
    end
    check({tag, "_clear_cycles_256"}, 64'(ca), 64'd256);
    check({tag, "_clear_cycles_100"}, 64'(cb), 64'd100);
    check({tag, "_fetch_ready"}, 64'(a_fetch_ready), 64'd1);
  endtask

  initial begin
    reset      = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    load_last  = 1'b0;
    tick();
    tick();
    check("rst_busy", 64'(a_busy), 64'd1);
    check("rst_fetch_ready", 64'(a_fetch_ready), 64'd0);
    check("rst_load_ready", 64'(a_load_ready), 64'd0);
    check("rst_fetch_valid", 64'(a_fetch_valid), 64'd0);
    check("rst_fetch_data", 64'(a_fetch_data), 64'd0);
    check("rst_fetch_oob", 64'(a_fetch_oob), 64'd0);
    check("rst_load_count", 64'(a_load_count), 64'd0);
    check("rst_load_err", 64'(a_load_err), 64'd0);
    reset = 1'b0;

    // 1: clear sweep length, then fetches of cleared words
    wait_clear("t1");
    fetch1(8'd0);
    check("t1_valid_0", 64'(a_fetch_valid), 64'd1);
    check("t1_data_0", 64'(a_fetch_data), 64'd0);
    tick();
    check("t1_valid_idle", 64'(a_fetch_valid), 64'd0);
    fetch1(8'd128);
    check("t1_data_128", 64'(a_fetch_data), 64'd0);
    fetch1(8'd255);
    check("t1_valid_255", 64'(a_fetch_valid), 64'd1);
    check("t1_oob_255", 64'(a_fetch_oob), 64'd0);

    // 2: three-word burst then back-to-back fetches
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("t2_load_ready", 64'(a_load_ready), 64'd1);
    check("t2_busy_load", 64'(a_busy), 64'd1);
    load_word(8'd0, 35'h1_2345_6789, 1'b0);
    load_word(8'd1, 35'h7_FFFF_FFFF, 1'b0);
    load_word(8'd2, 35'h0_0000_0001, 1'b1);
    check("t2_load_count", 64'(a_load_count), 64'd3);
    check("t2_back_run", 64'(a_fetch_ready), 64'd1);
    fetch_req  = 1'b1;
    fetch_addr = 8'd0;
    tick();
    check("t2_v0", 64'(a_fetch_valid), 64'd1);
    check("t2_d0", 64'(a_fetch_data), 64'h1_2345_6789);
    fetch_addr = 8'd1;
    tick();
    check("t2_v1", 64'(a_fetch_valid), 64'd1);
    check("t2_d1", 64'(a_fetch_data), 64'h7_FFFF_FFFF);
    fetch_addr = 8'd2;
    tick();
    check("t2_v2", 64'(a_fetch_valid), 64'd1);
    check("t2_d2", 64'(a_fetch_data), 64'h0_0000_0001);
    fetch_req = 1'b0;
    tick();
    check("t2_v_drop", 64'(a_fetch_valid), 64'd0);
    check("t2_d_hold", 64'(a_fetch_data), 64'h0_0000_0001);

    // 3: out-of-range fetch and load on the DEPTH=100 instance
    fetch1(8'd100);
    check("t3_oob_valid", 64'(b_fetch_valid), 64'd1);
    check("t3_oob_data", 64'(b_fetch_data), 64'd0);
    check("t3_oob_flag", 64'(b_fetch_oob), 64'd1);
    check("t3_inrange_flag_256", 64'(a_fetch_oob), 64'd0);
    tick();
    check("t3_oob_drop", 64'(b_fetch_oob), 64'd0);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_word(8'd200, 35'h5_5555_5555, 1'b1);
    check("t3_load_err", 64'(b_load_err), 64'd1);
    check("t3_load_count", 64'(b_load_count), 64'd1);
    check("t3_no_err_256", 64'(a_load_err), 64'd0);
    fetch1(8'd200);
    check("t3_dropped_data", 64'(b_fetch_data), 64'd0);
    check("t3_written_256", 64'(a_fetch_data), 64'h5_5555_5555);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("t3_err_cleared", 64'(b_load_err), 64'd0);
    load_word(8'd5, 35'h0_0000_0055, 1'b1);
    check("t3_back_run", 64'(b_fetch_ready), 64'd1);

    // 4: fetch and load_start together; fetches during LOAD are ignored
    fetch_req  = 1'b1;
    fetch_addr = 8'd1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("t4_fetch_valid", 64'(a_fetch_valid), 64'd1);
    check("t4_fetch_data", 64'(a_fetch_data), 64'h7_FFFF_FFFF);
    check("t4_fetch_ready", 64'(a_fetch_ready), 64'd0);
    check("t4_load_ready", 64'(a_load_ready), 64'd1);
    tick();
    check("t4_no_valid_1", 64'(a_fetch_valid), 64'd0);
    tick();
    check("t4_no_valid_2", 64'(a_fetch_valid), 64'd0);
    fetch_req = 1'b0;
    check("t4_data_hold", 64'(a_fetch_data), 64'h7_FFFF_FFFF);

    // 6: valid gaps and load_last without load_valid (still in LOAD from test 4)
    load_word(8'd10, 35'h0_0000_000A, 1'b0);
    load_valid = 1'b0;
    load_addr  = 8'd11;
    load_data  = 35'h0_0000_000B;
    load_last  = 1'b1;
    tick();
    load_last = 1'b0;
    check("t6_last_no_valid", 64'(a_load_ready), 64'd1);
    tick();
    check("t6_count_gap", 64'(a_load_count), 64'd1);
    load_word(8'd12, 35'h0_0000_000C, 1'b0);
    check("t6_count_2", 64'(a_load_count), 64'd2);
    check("t6_still_load", 64'(a_load_ready), 64'd1);
    load_word(8'd13, 35'h0_0000_000D, 1'b1);
    check("t6_count_3", 64'(a_load_count), 64'd3);
    check("t6_run", 64'(a_fetch_ready), 64'd1);
    fetch1(8'd10);
    check("t6_d10", 64'(a_fetch_data), 64'hA);
    fetch1(8'd11);
    check("t6_d11", 64'(a_fetch_data), 64'h0);
    fetch1(8'd12);
    check("t6_d12", 64'(a_fetch_data), 64'hC);
    fetch1(8'd13);
    check("t6_d13", 64'(a_fetch_data), 64'hD);

    // 5: reset in the middle of a load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_word(8'd20, 35'h0_0000_0003, 1'b0);
    load_word(8'd21, 35'h0_0000_0004, 1'b0);
    check("t5_count_2", 64'(a_load_count), 64'd2);
    reset = 1'b1;
    tick();
    check("t5_rst_busy", 64'(a_busy), 64'd1);
    check("t5_rst_load_ready", 64'(a_load_ready), 64'd0);
    check("t5_rst_count", 64'(a_load_count), 64'd0);
    reset = 1'b0;
    wait_clear("t5");
    fetch1(8'd20);
    check("t5_d20", 64'(a_fetch_data), 64'd0);
    fetch1(8'd21);
    check("t5_d21", 64'(a_fetch_data), 64'd0);
    fetch1(8'd0);
    check("t5_d0", 64'(a_fetch_data), 64'd0);
    check("t5_count", 64'(a_load_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prog_mem_sync.md
Name: prog_mem_sync

Overview:
- Synchronous, writable program memory. Replaces the hard-coded asynchronous instruction ROM in front of the CPU fetch stage.
- Width and depth are parametrised.
- After reset, the whole array is cleared to NOP (all-zero word).
- A loader port with a valid/ready handshake writes a new program at run time.
- Fetches use a registered request/response handshake with one-cycle latency.

Parameters:
DATA_W, 35, instruction word width in bits; the NOP encoding is all zeros.
ADDR_W, 8, address width in bits.
DEPTH, 256, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_W.

Ports:
clk  in  1  single clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
fetch_req  in  1  fetch request; sampled only when fetch_ready=1.
fetch_addr  in  ADDR_W  fetch address.
fetch_ready  out  1  high only in RUN.
fetch_valid  out  1  registered; high for one cycle per accepted fetch.
fetch_data  out  DATA_W  registered instruction word.
fetch_oob  out  1  registered; high with fetch_valid when the fetched address was >= DEPTH.
load_start  in  1  request to enter LOAD; honoured only in RUN.
load_valid  in  1  loader word valid.
load_ready  out  1  high only in LOAD.
load_addr  in  ADDR_W  loader write address.
load_data  in  DATA_W  loader write data.
load_last  in  1  marks the final word of the load burst.
load_count  out  ADDR_W+1  number of words accepted in the current or most recent load.
load_err  out  1  sticky flag: a load word targeted an address >= DEPTH.
busy  out  1  high in CLEAR and LOAD.

Behaviour:
- State machine with three states: CLEAR, RUN, LOAD. Reset forces CLEAR from any state, including mid-LOAD and mid-CLEAR.
- Output values while reset is asserted and in the first cycle after it:
  - fetch_valid=0, fetch_data=0, fetch_oob=0.
  - fetch_ready=0, load_ready=0.
  - load_count=0, load_err=0, busy=1.
- CLEAR state:
  - An internal pointer runs 0..DEPTH-1 and writes 0 to one word per cycle.
  - After the write to DEPTH-1, the next state is RUN. CLEAR lasts exactly DEPTH cycles.
  - fetch_req and load_start are ignored.
- RUN state, fetch:
  - If fetch_req=1 at edge N, then at edge N+1: fetch_valid=1 and fetch_data=mem[fetch_addr sampled at N].
  - A fetch can be accepted every cycle, so back-to-back fetches give fetch_valid held high.
  - If fetch_addr >= DEPTH: fetch_data=0 (NOP) and fetch_oob=1.
  - fetch_data holds its last value when fetch_valid=0.
- RUN state, entering LOAD:
  - load_start=1 moves the state to LOAD on the next edge and clears load_count and load_err.
  - If fetch_req and load_start are both high in the same cycle, the fetch is accepted and completes normally, and the state still moves to LOAD.
- LOAD state:
  - load_ready=1 and fetch_ready=0; fetch_valid drops to 0 one cycle after entry.
  - A word is accepted on any edge where load_valid=1 (load_ready is already 1).
  - If load_addr < DEPTH, the word is written to mem[load_addr]. Otherwise the write is dropped and load_err is set (sticky).
  - load_count increments on every accepted word, whether or not the write was dropped, and saturates at 2**ADDR_W.
  - An accepted word with load_last=1 returns the state to RUN on the next edge; the last word is written.
  - load_last without load_valid has no effect. load_start is ignored in LOAD.
- Write/read ordering: there is no fetch during LOAD, so there is no read/write collision. The first fetch after LOAD returns the newly loaded data.
- Storage is an inferred synchronous single-port-write RAM. The read and the fetch_data register are the same cycle, giving one-cycle latency; there is no combinational path from fetch_addr to fetch_data.

Test Plan:
1. Reset with DEPTH=256 -> busy=1 and fetch_ready=0 for 256 cycles, then fetch_ready=1. Fetches of addresses 0, 128 and 255 return fetch_data=0 with fetch_valid one cycle after each request.
2. Load burst {0:0x1_2345_6789, 1:0x7_FFFF_FFFF, 2:0x0_0000_0001 with load_last} -> load_count=3, state back to RUN. Back-to-back fetches of 0, 1, 2 return the same words on three consecutive cycles with fetch_valid held high.
3. DEPTH=100, fetch address 100 -> fetch_valid=1, fetch_data=0, fetch_oob=1. Load a word to address 200 -> load_err=1, word dropped, load_count=1. A later load_start clears load_err to 0.
4. fetch_req and load_start in the same cycle -> that fetch completes with valid data. fetch_ready=0 from the next cycle, and fetch_req during LOAD produces no fetch_valid.
5. Reset asserted mid-LOAD after 2 words -> CLEAR runs for DEPTH cycles. Afterwards, fetches of the loaded addresses return 0 and load_count=0.
6. Gaps in load_valid (pattern 1,0,0,1) and load_last=1 with load_valid=0 -> only the valid-qualified words are counted and written. The state stays in LOAD until a valid word carries load_last.
